// File: rtl/sar_search_if.sv
// sar_search_if: probe/flag link between the search engine and an external magnitude comparator, plus the search control and status signals.
interface sar_search_if #(
  parameter int WIDTH = 4,
  parameter int CW = 3
);
  logic start;
  logic AEQB;
  logic AGTB;
  logic ALTB;
  logic [WIDTH-1:0] A;
  logic busy;
  logic done;
  logic found;
  logic err;
  logic [WIDTH-1:0] result;
  logic [CW-1:0] ncmp;
  modport master (
    input start, AEQB, AGTB, ALTB,
    output A, busy, done, found, err, result, ncmp
  );
  modport slave (
    output start, AEQB, AGTB, ALTB,
    input A, busy, done, found, err, result, ncmp
  );
endinterface

// File: rtl/sar_search.sv
// sar_search: binary search that recovers an unknown operand B using only the AEQB/AGTB/ALTB flags of an external comparator.
module sar_search #(
  parameter int WIDTH = 4,
  parameter int CW = 3
) (
  input logic clk,
  input logic rst,
  sar_search_if.master s
);
  localparam int BW = WIDTH + 1;
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] a_q, a_d, result_q, result_d;
  logic found_q, found_d, err_q, err_d;
  logic [CW-1:0] ncmp_q, ncmp_d;
  logic [BW-1:0] hi_dec, lo_inc;
  logic empty_gt, empty_lt;
  // hi may drop to -1, so it is sign-extended; lo never goes negative
  assign hi_dec = {1'b0, a_q} - 1'b1;
  assign lo_inc = {1'b0, a_q} + 1'b1;
  assign empty_gt = $signed({1'b0, lo_q}) > $signed({hi_dec[BW-1], hi_dec});
  assign empty_lt = lo_inc > hi_q;
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    hi_d = hi_q;
    a_d = a_q;
    result_d = result_q;
    found_d = found_q;
    err_d = err_q;
    ncmp_d = ncmp_q;
    case (state_q)
      IDLE: if (s.start) begin
        lo_d = '0;
        hi_d = {1'b0, {WIDTH{1'b1}}};
        a_d = {1'b0, {(WIDTH-1){1'b1}}};
        ncmp_d = '0;
        found_d = 1'b0;
        err_d = 1'b0;
        result_d = '0;
        state_d = PROBE;
      end
      PROBE: begin
        ncmp_d = ncmp_q + 1'b1;
        if (!$onehot({s.AEQB, s.AGTB, s.ALTB})) begin
          err_d = 1'b1;
          found_d = 1'b0;
          state_d = DONE;
        end else if (s.AEQB) begin
          result_d = a_q;
          found_d = 1'b1;
          state_d = DONE;
        end else if (s.AGTB) begin
          hi_d = hi_dec;
          err_d = empty_gt;
          state_d = empty_gt ? DONE : PROBE;
          a_d = empty_gt ? a_q : WIDTH'((lo_q + hi_dec) >> 1);
        end else begin
          lo_d = lo_inc;
          err_d = empty_lt;
          state_d = empty_lt ? DONE : PROBE;
          a_d = empty_lt ? a_q : WIDTH'((lo_inc + hi_q) >> 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      a_q <= '0;
      result_q <= '0;
      found_q <= 1'b0;
      err_q <= 1'b0;
      ncmp_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      a_q <= a_d;
      result_q <= result_d;
      found_q <= found_d;
      err_q <= err_d;
      ncmp_q <= ncmp_d;
    end
  end
  assign s.A = a_q;
  assign s.busy = state_q == PROBE;
  assign s.done = state_q == DONE;
  assign s.found = found_q;
  assign s.err = err_q;
  assign s.result = result_q;
  assign s.ncmp = ncmp_q;
endmodule
